// File: rtl/settle_filter.sv
// settle_filter
// -------------
// Receiving-end sampler for the outputs of delay-modelled combinational gate
// networks. The asynchronous input is first passed through a two-flop
// synchronizer. A new value is committed to the output only after it has been
// seen on the synchronized input for SETTLE consecutive clocks. Transients
// that disappear before settling are rejected and counted.
//
// Parameters:
//   WIDTH     - width of din/dout
//   SETTLE    - consecutive synchronized cycles a new value must hold (2..255)
//   RESET_VAL - reset value of dout, the candidate and both synchronizer stages
//   GCW       - width of the saturating glitch counter
//
// Ports:
//   clk        - clock, rising edge
//   rst_b      - asynchronous active-low reset
//   din        - asynchronous input from gate-level logic
//   clr_glitch - synchronous clear of glitch_cnt (wins over a same-cycle glitch)
//   dout       - filtered, committed value
//   upd        - one-cycle pulse in the cycle dout takes a new value
//   stable     - 1 while no new value is pending (FSM idle)
//   glitch_cnt - saturating count of rejected transients
module settle_filter #(
    parameter int                 WIDTH     = 1,
    parameter int                 SETTLE    = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 GCW       = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_glitch,
    output logic [WIDTH-1:0] dout,
    output logic             upd,
    output logic             stable,
    output logic [GCW-1:0]   glitch_cnt
);

    localparam int CW = $clog2(SETTLE + 1);

    // The candidate has been seen for SETTLE cycles when the counter reaches
    // this value while the synchronized input still matches it.
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic {
        IDLE,
        SETTLING
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] dout_nxt;
    logic             upd_nxt;
    logic             glitch_ev;
    logic [GCW-1:0]   glitch_nxt;

    // Two-flop synchronizer; everything downstream looks at s2 only.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Next-state logic. The whole vector is compared at once, so any bit
    // change restarts settling. A candidate that is displaced before it has
    // settled counts as a glitch, whether the input fell back to the
    // committed value or moved on to yet another value.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        upd_nxt   = 1'b0;
        glitch_ev = 1'b0;
        case (state)
            IDLE: begin
                if (s2 != dout) begin
                    cand_nxt  = s2;
                    cnt_nxt   = CW'(1);
                    state_nxt = SETTLING;
                end
            end
            SETTLING: begin
                if (s2 == cand) begin
                    if (cnt == LAST) begin
                        dout_nxt  = cand;
                        upd_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else if (s2 == dout) begin
                    glitch_ev = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    glitch_ev = 1'b1;
                    cand_nxt  = s2;
                    cnt_nxt   = CW'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Glitch counter: clear has priority, otherwise count up and stick at
    // all-ones rather than wrapping.
    always_comb begin
        glitch_nxt = glitch_cnt;
        if (clr_glitch) begin
            glitch_nxt = '0;
        end else if (glitch_ev && (glitch_cnt != '1)) begin
            glitch_nxt = glitch_cnt + 1'b1;
        end
    end

    // State and output registers. Reset drops any pending candidate without
    // committing it or counting it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            cand       <= RESET_VAL;
            cnt        <= '0;
            dout       <= RESET_VAL;
            upd        <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            dout       <= dout_nxt;
            upd        <= upd_nxt;
            glitch_cnt <= glitch_nxt;
        end
    end

    assign stable = (state == IDLE);

endmodule
